// File: rtl/ctrl_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ctrl_sequencer                                                |
// | Purpose  : Five-state multi-cycle control sequencer. Steps FETCH, DECODE,|
// |            EXE, MEM and WB once per instruction and builds the 32-bit    |
// |            data-path control word plus memory strobes from the current   |
// |            instruction.                                                  |
// | Ports    : CLK         - rising-edge clock                               |
// |            RST         - synchronous active-high reset                   |
// |            INSTRUCTION - instruction register (opcode [31:26],           |
// |                          funct [5:0])                                    |
// |            ZERO        - ALU zero flag, sampled in WB for branches       |
// |            CTRL        - data-path control word                          |
// |            READ/WRITE  - memory strobes                                  |
// |            STATE       - current state code (debug)                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ctrl_sequencer (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTRUCTION,
    input  logic        ZERO,
    output logic [31:0] CTRL,
    output logic        READ,
    output logic        WRITE,
    output logic [2:0]  STATE
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] c_ALU_ADD = 6'd1, c_ALU_SUB = 6'd2, c_ALU_MUL = 6'd3,
                           c_ALU_SHR = 6'd4, c_ALU_SHL = 6'd5, c_ALU_AND = 6'd6,
                           c_ALU_OR  = 6'd7, c_ALU_NOR = 6'd8, c_ALU_SLT = 6'd9;

    localparam logic [5:0] c_OP_RTYPE = 6'h00, c_OP_ADDI = 6'h08, c_OP_MULI = 6'h1d,
                           c_OP_SLTI  = 6'h0a, c_OP_ANDI = 6'h0c, c_OP_ORI  = 6'h0d,
                           c_OP_LUI   = 6'h0f, c_OP_LW   = 6'h23, c_OP_SW   = 6'h2b,
                           c_OP_BEQ   = 6'h04, c_OP_BNE  = 6'h05, c_OP_JMP  = 6'h02,
                           c_OP_JAL   = 6'h03, c_OP_PUSH = 6'h1b, c_OP_POP  = 6'h1c;

    localparam logic [5:0] c_FN_ADD = 6'h20, c_FN_SUB = 6'h22, c_FN_MUL = 6'h2c,
                           c_FN_AND = 6'h24, c_FN_OR  = 6'h25, c_FN_NOR = 6'h27,
                           c_FN_SLT = 6'h2a, c_FN_SLL = 6'h01, c_FN_SRL = 6'h02,
                           c_FN_JR  = 6'h08;

    localparam logic [1:0] c_PC_SEQ = 2'd0, c_PC_R1 = 2'd1, c_PC_BR = 2'd2, c_PC_JMP = 2'd3;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_valid;
    logic [5:0]  w_oprn;
    logic [31:0] w_sel;      // operand, write-data and memory-path selects (EXE..WB)
    logic [31:0] w_rsel;     // register-address selects (DECODE..WB)
    logic [31:0] w_hold;
    logic        w_reg_wr;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_sp_exe;
    logic        w_sp_wb;
    logic [1:0]  w_pc_mode;
    logic        w_br_ne;
    logic        w_taken;
    logic [31:0] w_ctrl;
    logic        w_read;
    logic        w_write;
    logic        w_unused;

    assign w_opcode = INSTRUCTION[31:26];
    assign w_funct  = INSTRUCTION[5:0];
    assign w_unused = ^INSTRUCTION[25:6];

    // Instruction decode: everything the later states need, independent of state.
    always_comb begin
        w_valid   = 1'b1;
        w_oprn    = '0;
        w_sel     = '0;
        w_rsel    = '0;
        w_reg_wr  = 1'b0;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_sp_exe  = 1'b0;
        w_sp_wb   = 1'b0;
        w_pc_mode = c_PC_SEQ;
        w_br_ne   = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_reg_wr  = 1'b1;
                w_rsel[17] = 1'b1;
                w_sel[20]  = 1'b1;
                w_sel[25]  = 1'b1;
                case (w_funct)
                    c_FN_ADD: w_oprn = c_ALU_ADD;
                    c_FN_SUB: w_oprn = c_ALU_SUB;
                    c_FN_MUL: w_oprn = c_ALU_MUL;
                    c_FN_AND: w_oprn = c_ALU_AND;
                    c_FN_OR:  w_oprn = c_ALU_OR;
                    c_FN_NOR: w_oprn = c_ALU_NOR;
                    c_FN_SLT: w_oprn = c_ALU_SLT;
                    c_FN_SLL: begin w_oprn = c_ALU_SHL; w_sel[25] = 1'b0; w_sel[24] = 1'b1; end
                    c_FN_SRL: begin w_oprn = c_ALU_SHR; w_sel[25] = 1'b0; w_sel[24] = 1'b1; end
                    c_FN_JR: begin
                        w_reg_wr   = 1'b0;
                        w_rsel[17] = 1'b0;
                        w_sel[20]  = 1'b0;
                        w_sel[25]  = 1'b0;
                        w_pc_mode  = c_PC_R1;
                    end
                    default: w_valid = 1'b0;
                endcase
            end
            c_OP_ADDI, c_OP_MULI, c_OP_SLTI, c_OP_ANDI, c_OP_ORI, c_OP_LUI: begin
                w_reg_wr   = 1'b1;
                w_rsel[15] = 1'b1;
                w_rsel[17] = 1'b1;
                w_sel[20]  = 1'b1;
                case (w_opcode)
                    c_OP_ADDI: begin w_oprn = c_ALU_ADD; w_sel[23] = 1'b1; end
                    c_OP_MULI: begin w_oprn = c_ALU_MUL; w_sel[23] = 1'b1; end
                    c_OP_SLTI: begin w_oprn = c_ALU_SLT; w_sel[23] = 1'b1; end
                    c_OP_ANDI: w_oprn = c_ALU_AND;
                    c_OP_ORI:  w_oprn = c_ALU_OR;
                    default:   w_sel[19] = 1'b1;   // lui: write data is imm<<16, ALU idle
                endcase
            end
            c_OP_LW: begin
                w_oprn     = c_ALU_ADD;
                w_sel[23]  = 1'b1;
                w_mem_rd   = 1'b1;
                w_reg_wr   = 1'b1;
                w_rsel[15] = 1'b1;
                w_rsel[17] = 1'b1;
                w_sel[18]  = 1'b1;
                w_sel[20]  = 1'b1;
            end
            c_OP_SW: begin
                w_oprn    = c_ALU_ADD;
                w_sel[23] = 1'b1;
                w_mem_wr  = 1'b1;
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_oprn    = c_ALU_SUB;
                w_sel[25] = 1'b1;
                w_pc_mode = c_PC_BR;
                w_br_ne   = (w_opcode == c_OP_BNE);
            end
            c_OP_JMP: w_pc_mode = c_PC_JMP;
            c_OP_JAL: begin
                w_pc_mode  = c_PC_JMP;
                w_reg_wr   = 1'b1;
                w_rsel[16] = 1'b1;
            end
            c_OP_PUSH: begin
                // SP-1 is computed in EXE but SP is only committed in WB,
                // so MEM still addresses the old SP.
                w_oprn     = c_ALU_SUB;
                w_sel[21]  = 1'b1;
                w_sel[22]  = 1'b1;
                w_sel[24]  = 1'b1;
                w_sel[26]  = 1'b1;
                w_sel[27]  = 1'b1;
                w_rsel[14] = 1'b1;
                w_mem_wr   = 1'b1;
                w_sp_wb    = 1'b1;
            end
            c_OP_POP: begin
                // SP+1 is committed at the end of EXE so MEM reads the new top.
                w_oprn    = c_ALU_ADD;
                w_sel[21] = 1'b1;
                w_sel[22] = 1'b1;
                w_sel[24] = 1'b1;
                w_sel[27] = 1'b1;
                w_mem_rd  = 1'b1;
                w_sp_exe  = 1'b1;
                w_reg_wr  = 1'b1;
                w_sel[18] = 1'b1;
                w_sel[20] = 1'b1;
            end
            default: w_valid = 1'b0;
        endcase

        // Undefined encodings collapse to a NOP: nothing but the sequential PC update.
        if (!w_valid) begin
            w_oprn    = '0;
            w_sel     = '0;
            w_rsel    = '0;
            w_reg_wr  = 1'b0;
            w_mem_rd  = 1'b0;
            w_mem_wr  = 1'b0;
            w_sp_exe  = 1'b0;
            w_sp_wb   = 1'b0;
            w_pc_mode = c_PC_SEQ;
            w_br_ne   = 1'b0;
        end
    end

    // Fields held constant from EXE through WB.
    assign w_hold  = w_sel | w_rsel | {21'b0, w_oprn, w_valid, 4'b0};
    assign w_taken = ZERO ^ w_br_ne;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_ctrl       = '0;
        w_read       = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next_state = S_DECODE;
                w_ctrl[28]   = 1'b1;
                w_ctrl[1]    = 1'b1;
                w_read       = 1'b1;
            end
            S_DECODE: begin
                w_next_state = S_EXE;
                w_ctrl       = w_rsel;
                w_ctrl[4]    = 1'b1;
            end
            S_EXE: begin
                w_next_state = S_MEM;
                w_ctrl       = w_hold;
                w_ctrl[2]    = w_sp_exe;
            end
            S_MEM: begin
                w_next_state = S_WB;
                w_ctrl       = w_hold;
                w_read       = w_mem_rd;
                w_write      = w_mem_wr;
            end
            S_WB: begin
                w_next_state = S_FETCH;
                w_ctrl       = w_hold;
                w_ctrl[0]    = 1'b1;
                w_ctrl[2]    = w_sp_wb;
                w_ctrl[3]    = w_reg_wr;
                case (w_pc_mode)
                    c_PC_SEQ: begin w_ctrl[11] = 1'b1; w_ctrl[13] = 1'b1; end
                    c_PC_R1:  w_ctrl[13] = 1'b1;
                    c_PC_BR: begin
                        w_ctrl[13] = 1'b1;
                        w_ctrl[12] = w_taken;
                        w_ctrl[11] = ~w_taken;
                    end
                    default: ;   // jump address path: bits 11..13 stay 0
                endcase
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Reset gates the outputs combinationally so an aborted instruction has no effect.
    assign CTRL  = RST ? '0 : w_ctrl;
    assign READ  = ~RST & w_read;
    assign WRITE = ~RST & w_write;
    assign STATE = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ctrl_sequencer                                             |
// | Purpose  : Scoreboard bench for ctrl_sequencer. The driver pushes the    |
// |            expected state/CTRL/READ/WRITE for each cycle; a monitor pops |
// |            and compares on the falling edge.                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ctrl_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INSTRUCTION;
    logic        ZERO;
    logic [31:0] CTRL;
    logic        READ;
    logic        WRITE;
    logic [2:0]  STATE;

    ctrl_sequencer u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSTRUCTION (INSTRUCTION),
        .ZERO        (ZERO),
        .CTRL        (CTRL),
        .READ        (READ),
        .WRITE       (WRITE),
        .STATE       (STATE)
    );

    always #5 CLK = ~CLK;

    // Instruction properties, phrased as the instruction set describes them.
    localparam int OP2_NONE = 0, OP2_R2 = 1, OP2_SHAMT = 2, OP2_SEXT = 3, OP2_ZEXT = 4, OP2_ONE = 5;
    localparam int WD_NONE = 0, WD_ALU = 1, WD_MEM = 2, WD_LUI = 3, WD_PC1 = 4;
    localparam int DST_NONE = 0, DST_RD = 1, DST_RT = 2, DST_R31 = 3, DST_R0 = 4;
    localparam int MEM_NONE = 0, MEM_RD_ALU = 1, MEM_WR_ALU = 2, MEM_WR_SP = 3, MEM_RD_SP = 4;
    localparam int PC_SEQ = 0, PC_R1 = 1, PC_BEQ = 2, PC_BNE = 3, PC_JMP = 4;
    localparam int SP_NONE = 0, SP_EXE = 1, SP_WB = 2;

    typedef struct {
        bit valid;
        int alu;
        bit op1_sp;
        int op2;
        int wd;
        int dest;
        int mem;
        int pc;
        int sp_ld;
        bit rs_r0;
    } desc_t;

    typedef struct {
        logic [2:0]  state;
        logic [31:0] ctrl;
        logic        rd;
        logic        wr;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_phase = 0;
    int   n_ins   = 0;

    function automatic desc_t decode_ins(input logic [31:0] ins);
        desc_t d;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        d = '{valid:1'b1, alu:0, op1_sp:1'b0, op2:OP2_NONE, wd:WD_NONE, dest:DST_NONE,
              mem:MEM_NONE, pc:PC_SEQ, sp_ld:SP_NONE, rs_r0:1'b0};
        case (op)
            6'h00: begin
                d.op2 = OP2_R2; d.wd = WD_ALU; d.dest = DST_RD;
                case (fn)
                    6'h20: d.alu = 1;
                    6'h22: d.alu = 2;
                    6'h2c: d.alu = 3;
                    6'h24: d.alu = 6;
                    6'h25: d.alu = 7;
                    6'h27: d.alu = 8;
                    6'h2a: d.alu = 9;
                    6'h01: begin d.alu = 5; d.op2 = OP2_SHAMT; end
                    6'h02: begin d.alu = 4; d.op2 = OP2_SHAMT; end
                    6'h08: begin d.op2 = OP2_NONE; d.wd = WD_NONE; d.dest = DST_NONE; d.pc = PC_R1; end
                    default: d.valid = 1'b0;
                endcase
            end
            6'h08: begin d.alu = 1; d.op2 = OP2_SEXT; d.wd = WD_ALU; d.dest = DST_RT; end
            6'h1d: begin d.alu = 3; d.op2 = OP2_SEXT; d.wd = WD_ALU; d.dest = DST_RT; end
            6'h0a: begin d.alu = 9; d.op2 = OP2_SEXT; d.wd = WD_ALU; d.dest = DST_RT; end
            6'h0c: begin d.alu = 6; d.op2 = OP2_ZEXT; d.wd = WD_ALU; d.dest = DST_RT; end
            6'h0d: begin d.alu = 7; d.op2 = OP2_ZEXT; d.wd = WD_ALU; d.dest = DST_RT; end
            6'h0f: begin d.wd = WD_LUI; d.dest = DST_RT; end
            6'h23: begin d.alu = 1; d.op2 = OP2_SEXT; d.mem = MEM_RD_ALU; d.wd = WD_MEM; d.dest = DST_RT; end
            6'h2b: begin d.alu = 1; d.op2 = OP2_SEXT; d.mem = MEM_WR_ALU; end
            6'h04: begin d.alu = 2; d.op2 = OP2_R2; d.pc = PC_BEQ; end
            6'h05: begin d.alu = 2; d.op2 = OP2_R2; d.pc = PC_BNE; end
            6'h02: d.pc = PC_JMP;
            6'h03: begin d.pc = PC_JMP; d.wd = WD_PC1; d.dest = DST_R31; end
            6'h1b: begin d.alu = 2; d.op1_sp = 1'b1; d.op2 = OP2_ONE; d.mem = MEM_WR_SP; d.rs_r0 = 1'b1; d.sp_ld = SP_WB; end
            6'h1c: begin d.alu = 1; d.op1_sp = 1'b1; d.op2 = OP2_ONE; d.mem = MEM_RD_SP; d.sp_ld = SP_EXE; d.wd = WD_MEM; d.dest = DST_R0; end
            default: d.valid = 1'b0;
        endcase
        if (!d.valid)
            d = '{valid:1'b0, alu:0, op1_sp:1'b0, op2:OP2_NONE, wd:WD_NONE, dest:DST_NONE,
                  mem:MEM_NONE, pc:PC_SEQ, sp_ld:SP_NONE, rs_r0:1'b0};
        return d;
    endfunction

    function automatic logic [31:0] addr_bits(input desc_t d);
        logic [31:0] w;
        w = '0;
        case (d.dest)
            DST_RD:  w[17] = 1'b1;
            DST_RT:  begin w[15] = 1'b1; w[17] = 1'b1; end
            DST_R31: w[16] = 1'b1;
            default: ;
        endcase
        if (d.rs_r0) w[14] = 1'b1;
        return w;
    endfunction

    function automatic logic [31:0] held_bits(input desc_t d);
        logic [31:0] w;
        w = '0;
        if (!d.valid) return w;
        w[4]    = 1'b1;
        w[10:5] = d.alu[5:0];
        if (d.op1_sp) w[21] = 1'b1;
        case (d.op2)
            OP2_R2:    w[25] = 1'b1;
            OP2_SHAMT: w[24] = 1'b1;
            OP2_SEXT:  w[23] = 1'b1;
            OP2_ONE:   begin w[24] = 1'b1; w[22] = 1'b1; end
            default: ;
        endcase
        case (d.wd)
            WD_ALU: w[20] = 1'b1;
            WD_MEM: begin w[20] = 1'b1; w[18] = 1'b1; end
            WD_LUI: begin w[20] = 1'b1; w[19] = 1'b1; end
            default: ;
        endcase
        case (d.mem)
            MEM_WR_SP: begin w[26] = 1'b1; w[27] = 1'b1; end
            MEM_RD_SP: w[27] = 1'b1;
            default: ;
        endcase
        return w | addr_bits(d);
    endfunction

    function automatic exp_t expect_for(input int ph, input logic rst, input logic [31:0] ins,
                                        input logic z, input string tag);
        exp_t  e;
        desc_t d;
        logic [31:0] h;
        bit taken;
        d = decode_ins(ins);
        h = held_bits(d);
        e.state = 3'(ph);
        e.ctrl  = '0;
        e.rd    = 1'b0;
        e.wr    = 1'b0;
        e.tag   = tag;
        if (rst) return e;
        case (ph)
            0: begin e.ctrl = 32'h1000_0002; e.rd = 1'b1; end
            1: e.ctrl = 32'h0000_0010 | addr_bits(d);
            2: begin e.ctrl = h; if (d.sp_ld == SP_EXE) e.ctrl[2] = 1'b1; end
            3: begin
                e.ctrl = h;
                e.rd   = (d.mem == MEM_RD_ALU) || (d.mem == MEM_RD_SP);
                e.wr   = (d.mem == MEM_WR_ALU) || (d.mem == MEM_WR_SP);
            end
            default: begin
                e.ctrl    = h;
                e.ctrl[0] = 1'b1;
                if (d.dest != DST_NONE) e.ctrl[3] = 1'b1;
                if (d.sp_ld == SP_WB)   e.ctrl[2] = 1'b1;
                case (d.pc)
                    PC_SEQ: begin e.ctrl[11] = 1'b1; e.ctrl[13] = 1'b1; end
                    PC_R1:  e.ctrl[13] = 1'b1;
                    PC_BEQ, PC_BNE: begin
                        taken = (d.pc == PC_BEQ) ? z : !z;
                        e.ctrl[13] = 1'b1;
                        if (taken) e.ctrl[12] = 1'b1;
                        else       e.ctrl[11] = 1'b1;
                    end
                    default: ;
                endcase
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [5:0]  ops [0:18];
        logic [5:0]  fns [0:10];
        logic [31:0] r;
        int k;
        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h1d, 6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h23,
                6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h1b, 6'h1c, 6'h3f, 6'h00};
        fns = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02, 6'h08, 6'h3e};
        r = $urandom;
        k = $urandom_range(0, 19);
        if (k < 19) r[31:26] = ops[k];
        if (r[31:26] == 6'h00) begin
            k = $urandom_range(0, 11);
            if (k < 11) r[5:0] = fns[k];
        end
        return r;
    endfunction

    task automatic cycle(input logic rst, input logic [31:0] ins, input logic z);
        RST         = rst;
        INSTRUCTION = ins;
        ZERO        = z;
        exp_q.push_back(expect_for(m_phase, rst, ins, z,
                        $sformatf("ins%0d_ph%0d%s", n_ins, m_phase, rst ? "_rst" : "")));
        @(posedge CLK);
        #1;
        m_phase = rst ? 0 : (m_phase + 1) % 5;
    endtask

    // One instruction from FETCH; rst_at names a phase in which to reset (or -1).
    task automatic run_instr(input logic [31:0] ins, input logic z_wb, input int rst_at);
        logic [31:0] drv;
        logic        z;
        n_ins++;
        for (int p = 0; p < 5; p++) begin
            drv = (p == 0) ? 32'($urandom) : ins;
            z   = (p == 4) ? z_wb : 1'($urandom);
            cycle(p == rst_at, drv, z);
            if (p == rst_at) break;
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (STATE !== mon_e.state || CTRL !== mon_e.ctrl || READ !== mon_e.rd || WRITE !== mon_e.wr) begin
                n_fail++;
                $display("FAIL %s: got state=%0d ctrl=%08h read=%0b write=%0b, want state=%0d ctrl=%08h read=%0b write=%0b",
                         mon_e.tag, STATE, CTRL, READ, WRITE, mon_e.state, mon_e.ctrl, mon_e.rd, mon_e.wr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST         = 1'b1;
        INSTRUCTION = '0;
        ZERO        = 1'b0;
        @(posedge CLK);
        #1;
        m_phase = 0;
        cycle(1'b1, 32'h0, 1'b0);               // second reset cycle: outputs gated

        run_instr(32'h0022_1820, 1'b0, -1);     // add R3,R1,R2
        run_instr(32'h1022_0005, 1'b1, -1);     // beq, taken
        run_instr(32'h1022_0005, 1'b0, -1);     // beq, not taken
        run_instr(32'h1422_0003, 1'b0, -1);     // bne, taken
        run_instr(32'h6C20_0000, 1'b0, -1);     // push
        run_instr(32'h7000_0000, 1'b0, -1);     // pop
        run_instr(32'hAC22_0004, 1'b0, 3);      // sw, reset during MEM
        run_instr(32'hFC12_3456, 1'b0, -1);     // undefined opcode 0x3f
        run_instr(32'h0C00_0040, 1'b0, -1);     // jal
        run_instr(32'h0022_1808, 1'b0, -1);     // jr

        for (int i = 0; i < 300; i++)
            run_instr(rand_ins(), 1'($urandom),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);

        RST = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
